// File: rtl/cdc_rst_seq.sv
// Reset sequencer: async-assert/sync-release of async_clr, stretch, then staged per-channel release.
// Define CDC_RST_SEQ_ACK_EN to pace releases by per-channel rst_ack with a timeout instead of STAGE_DLY.
module cdc_rst_seq #(
   parameter int NUM_CH          = 4,
   parameter int SYNC_FF         = 4,
   parameter int STRETCH         = 16,
   parameter int STAGE_DLY       = 4,
   parameter int RST_ACTIVE_HIGH = 0,
   parameter int ACK_TIMEOUT     = 256
) (
   input  logic              clk,
   input  logic              async_clr,
   input  logic              sw_rst,
`ifdef CDC_RST_SEQ_ACK_EN
   input  logic [NUM_CH-1:0] rst_ack,
   output logic [NUM_CH-1:0] ack_timeout,
`endif
   output logic [NUM_CH-1:0] rst_out,
   output logic              rst_done
);

   typedef enum logic [1:0] {
      ST_RESET,
      ST_STRETCH,
      ST_RELEASE,
      ST_DONE
   } state_t;

   localparam int CNT_MAX = (STRETCH > STAGE_DLY)
                            ? ((STRETCH > ACK_TIMEOUT) ? STRETCH : ACK_TIMEOUT)
                            : ((STAGE_DLY > ACK_TIMEOUT) ? STAGE_DLY : ACK_TIMEOUT);
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0] STRETCH_END = CNT_W'(STRETCH);
   localparam logic             ASSERT_LVL  = (RST_ACTIVE_HIGH != 0);
`ifdef CDC_RST_SEQ_ACK_EN
   localparam logic [CNT_W-1:0] ACK_END     = CNT_W'(ACK_TIMEOUT - 1);
`else
   localparam logic [CNT_W-1:0] STAGE_END   = CNT_W'(STAGE_DLY - 1);
`endif

   state_t              state_q;
   logic [SYNC_FF-1:0]  syncChain_q;
   logic                syncClr_q;
   logic                syncClr_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [IDX_W-1:0]    idx_q;
   logic [IDX_W-1:0]    idxNext;
   logic [NUM_CH-1:0]   rstOut_q;
   logic                done_q;
   logic                advance;
`ifdef CDC_RST_SEQ_ACK_EN
   logic                ackSeen_q;
   logic [NUM_CH-1:0]   ackTo_q;
   logic                timedOut;
`endif

   always_ff @(posedge clk or posedge async_clr) begin
      if (async_clr) begin
         syncChain_q <= '1;
      end else begin
         syncChain_q <= {syncChain_q[SYNC_FF-2:0], 1'b0};
      end
   end

   // The FSM leaves RESET on the edge that clears the last sync flop, so it looks one stage ahead.
   assign syncClr_q = syncChain_q[SYNC_FF-1];
   assign syncClr_d = syncChain_q[SYNC_FF-2];
   assign idxNext   = idx_q + IDX_W'(1);

`ifdef CDC_RST_SEQ_ACK_EN
   always_comb begin
      advance  = 1'b0;
      timedOut = 1'b0;
      if (ackSeen_q) begin
         advance = 1'b1;
      end else if (!rst_ack[idx_q] && (cnt_q == ACK_END)) begin
         advance  = 1'b1;
         timedOut = 1'b1;
      end
   end
`else
   assign advance = (idx_q == LAST_IDX) || (cnt_q == STAGE_END);
`endif

   always_ff @(posedge clk or posedge async_clr) begin
      if (async_clr) begin
         state_q  <= ST_RESET;
         cnt_q    <= '0;
         idx_q    <= '0;
         rstOut_q <= {NUM_CH{ASSERT_LVL}};
         done_q   <= 1'b0;
`ifdef CDC_RST_SEQ_ACK_EN
         ackSeen_q <= 1'b0;
         ackTo_q   <= '0;
`endif
      end else if (state_q == ST_RESET) begin
         cnt_q <= '0;
         if (!syncClr_d) begin
            state_q <= ST_STRETCH;
         end
      end else if (syncClr_q || sw_rst) begin
         // A set sync flop here means a runt async_clr reached the chain but not the FSM.
         state_q  <= syncClr_q ? ST_RESET : ST_STRETCH;
         cnt_q    <= '0;
         idx_q    <= '0;
         rstOut_q <= {NUM_CH{ASSERT_LVL}};
         done_q   <= 1'b0;
`ifdef CDC_RST_SEQ_ACK_EN
         ackSeen_q <= 1'b0;
         ackTo_q   <= '0;
`endif
      end else begin
         case (state_q)
            ST_STRETCH: begin
               if (cnt_q == STRETCH_END) begin
                  state_q     <= ST_RELEASE;
                  cnt_q       <= '0;
                  idx_q       <= '0;
                  rstOut_q[0] <= ~ASSERT_LVL;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               if (advance) begin
                  cnt_q <= '0;
`ifdef CDC_RST_SEQ_ACK_EN
                  ackSeen_q <= 1'b0;
                  if (timedOut) begin
                     ackTo_q[idx_q] <= 1'b1;
                  end
`endif
                  if (idx_q == LAST_IDX) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q             <= idxNext;
                     rstOut_q[idxNext] <= ~ASSERT_LVL;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
`ifdef CDC_RST_SEQ_ACK_EN
                  if (rst_ack[idx_q]) begin
                     ackSeen_q <= 1'b1;
                  end
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign rst_out  = rstOut_q;
   assign rst_done = done_q;
`ifdef CDC_RST_SEQ_ACK_EN
   assign ack_timeout = ackTo_q;
`endif

endmodule

// File: doc/cdc_rst_seq.md
CDC_RST_SEQ -- requirements
Module: cdc_rst_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of reset output channels (1..32).
REQ-002 SHALL have parameter SYNC_FF, default 4, depth of the internal async-assert/sync-release chain (>=2).
REQ-003 SHALL have parameter STRETCH, default 16, minimum clk cycles all outputs stay asserted after synchronised release (>=1).
REQ-004 SHALL have parameter STAGE_DLY, default 4, clk cycles between successive channel releases (>=1).
REQ-005 SHALL have parameter RST_ACTIVE_HIGH, default 0, output polarity (0 means rst_out is active-low).
REQ-006 SHALL have parameter ACK_TIMEOUT, default 256, maximum wait in cycles for a per-channel ack (>=1, used only with REQ-025).
REQ-007 SHALL have port clk, input, 1, clock.
REQ-008 SHALL have port async_clr, input, 1, reset, asynchronous, active-high.
REQ-009 SHALL have port sw_rst, input, 1, synchronous software reset request in the clk domain, active-high.
REQ-010 SHALL have port rst_out, output, NUM_CH, per-channel reset with polarity per RST_ACTIVE_HIGH, bit 0 released first.
REQ-011 SHALL have port rst_done, output, 1, high when all channels are released.

Function
REQ-012 SHALL synchronise async_clr through SYNC_FF flops that are asynchronously set by async_clr and shift in 0, giving sync_clr.
REQ-013 SHALL implement states RESET, STRETCH, RELEASE and DONE with a cycle counter and a channel index.
REQ-014 In RESET, SHALL hold all rst_out asserted and move to STRETCH on the first edge where sync_clr is 0 (counter cleared).
REQ-015 In STRETCH, SHALL count STRETCH cycles and then move to RELEASE, deasserting rst_out[0] on that same edge (index 0).
REQ-016 In RELEASE, SHALL deassert rst_out[i+1] STAGE_DLY edges after rst_out[i], and enter DONE one edge after rst_out[NUM_CH-1] deasserts.
REQ-017 SHALL drive rst_done high in DONE only; once released, a channel SHALL stay released until a reset event.
REQ-018 With async_clr deasserted before edge 1, rst_out[i] SHALL release at edge SYNC_FF+1+STRETCH+i*STAGE_DLY, and rst_done SHALL rise at edge SYNC_FF+2+STRETCH+(NUM_CH-1)*STAGE_DLY.
REQ-019 sw_rst high at an edge in STRETCH, RELEASE or DONE SHALL re-assert all channels, clear rst_done, and enter STRETCH with counter 0. sw_rst held high SHALL keep the counter at 0.
REQ-020 sw_rst SHALL be ignored in RESET. When sw_rst and a release fall on the same edge, sw_rst SHALL win.
REQ-021 The counter SHALL be sized for max(STRETCH, STAGE_DLY, ACK_TIMEOUT) and SHALL never wrap.
REQ-022 With NUM_CH=1, the block SHALL go directly from releasing rst_out[0] to DONE.

Reset
REQ-023 async_clr high SHALL, without waiting for a clock, assert all rst_out, drive rst_done 0, set the sync chain, select state RESET and clear the counter, index and status. This SHALL hold at any point, including mid-RELEASE.
REQ-024 All outputs SHALL be registered, with no combinational path from any input other than the asynchronous async_clr.

Configuration
REQ-025 Macro CDC_RST_SEQ_ACK_EN SHALL add input rst_ack[NUM_CH] (clk domain, active-high) and output ack_timeout[NUM_CH] (sticky).
REQ-026 With CDC_RST_SEQ_ACK_EN defined, after channel i releases, the block SHALL release the next channel (or enter DONE for the last channel) one edge after rst_ack[i] is sampled high.
REQ-027 With CDC_RST_SEQ_ACK_EN defined, if rst_ack[i] is not seen within ACK_TIMEOUT cycles the block SHALL proceed anyway and set ack_timeout[i]; ack_timeout SHALL clear on async_clr or sw_rst; STAGE_DLY SHALL be unused.
REQ-028 Without CDC_RST_SEQ_ACK_EN, neither port SHALL exist and release timing SHALL follow REQ-016 exactly.

Verification (NUM_CH=4, SYNC_FF=4, STRETCH=8, STAGE_DLY=3, RST_ACTIVE_HIGH=0)
REQ-029 Bench SHALL cover: async_clr pulse then low before edge 1 -> rst_out bits 0..3 go 1 at edges 13/16/19/22, and rst_done=1 at edge 23.
REQ-030 Bench SHALL cover: async_clr rises mid-clock in DONE -> rst_out=4'b0000 and rst_done=0 before the next edge, then the REQ-029 sequence repeats.
REQ-031 Bench SHALL cover: sw_rst 1-cycle pulse at edge 17 -> rst_out=0000 after edge 17, and releases resume 9/12/15/18 edges later.
REQ-032 Bench SHALL cover: sw_rst held 20 cycles in DONE -> outputs stay 0000, and the first release comes 9 edges after sw_rst falls.
REQ-033 Bench SHALL cover: async_clr glitch shorter than 1 cycle during RELEASE -> all channels re-assert immediately, and the full sequence restarts.
REQ-034 Bench SHALL cover, with ACK_EN and ACK_TIMEOUT=5: rst_ack[1] never asserted -> ack_timeout=4'b0010, and rst_out[2] releases 5 cycles after rst_out[1].
